axi_sram_slave: RTL
===================

// Module: axi_sram_slave
// PURPOSE
// AXI3 responder for the CPU top's 32-bit AXI master port: memory-model slave for core-level benches.
// Answers the AR/R and AW/W/B channels from an internal word array.
// Read and write engines are independent; each has one burst in flight. Bursts up to 16 beats.
// Supported burst types: FIXED, INCR and WRAP.
// PARAMETERS
// ADDR_W  16  word-address bits; array holds 2^ADDR_W x 32b; byte address bits above ADDR_W+1 are ignored (aliasing)
// DELAY   3   extra response cycles, used only when AXI_SLV_DELAY_EN is defined (legal 0..15)
// PORTS
// clk                          in   1   clock; all logic on posedge
// rst                          in   1   asynchronous, active-high reset
// arid/awid                    in   4   request IDs, echoed on rid/bid
// araddr/awaddr                in   32  burst start byte address
// arlen/awlen                  in   4   beats-1
// arsize/awsize                in   3   bytes per beat = 1<<size (<=2)
// arburst/awburst              in   2   00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
// arlock/arcache/arprot/aw*    in   -   lock/cache/prot on both channels: accepted and ignored
// arvalid/awvalid/wvalid       in   1   master valids
// arready/awready/wready       out  1   slave readies
// rid/bid                      out  4   response IDs
// rdata                        out  32  read beat data
// rresp/bresp                  out  2   00 OKAY, 10 SLVERR
// rlast                        out  1   final read beat
// rvalid/bvalid                out  1   response valids
// rready/bready                in   1   master readies
// wid                          in   4   ignored (single write burst in flight, no interleaving)
// wdata/wstrb/wlast            in   32/4/1  write beat data, byte strobes, last flag
// BEHAVIOUR
// - Reset (async, immediate): all outputs 0; read and write FSMs go to IDLE.
//   Array contents are NOT reset. Reset mid-burst aborts it; beats already written remain.
// - arready/awready are registered: they rise the first clk after rst falls.
// - Read FSM R_IDLE -> R_BURST:
//   - R_IDLE: arready=1. AR handshake latches id/addr/len/size/burst and clears the beat count.
//   - R_BURST: rvalid=1 from the cycle after the AR handshake; rdata=mem[addr[ADDR_W+1:2]].
//   - rvalid/rdata/rlast/rid stay stable while rready=0.
//   - Each R handshake advances the address; the next beat is valid the following cycle.
//   - rlast=1 when beat count == len. The last handshake returns the FSM to R_IDLE.
//   - arready is back to 1 the cycle after the last handshake. rresp is always 00.
// - Write FSM W_IDLE -> W_DATA -> W_RESP:
//   - W_IDLE: awready=1. AW handshake latches id/addr/len/size/burst.
//   - W_DATA: wready=1. Each W handshake merges wdata into the addressed word per wstrb (byte lanes) and advances.
//   - Beats beyond len are accepted, not written. wlast handshake -> W_RESP.
//   - W_RESP: bvalid=1 with bid, held until bready. bresp=10 if wlast beat index != len, else 00.
//   - Then W_IDLE; awready=1 the cycle after the B handshake.
// - Address step: FIXED hold; INCR +1<<size; WRAP wraps within an aligned (len+1)<<size window.
// - 32-bit add, carry-out discarded (wrap-around past 0xFFFFFFFC).
// - Same word read and written in one cycle: rdata carries the pre-write value (read-before-write).
// - AR and AW in the same cycle are both accepted; the engines never stall each other.
// CONFIGURATION
// - AXI_SLV_DELAY_EN defined: the read FSM waits DELAY cycles in R_WAIT before R_BURST (first rvalid DELAY+1 cycles after AR).
//   The write FSM waits DELAY cycles in W_WAIT after the wlast handshake before bvalid.
//   Between beats there is no added delay.
// - Not defined: R_WAIT/W_WAIT absent, DELAY ignored, latencies as above.
// TESTING
// - Preload mem word 0x10 = 0xDEADBEEF; AR addr 0x40 len0 size2 id3 -> next cycle rvalid, rdata DEADBEEF, rid3, rlast1, rresp00.
// - INCR write 0x100 len7 data 0..7 wstrb F -> bvalid bresp00; read it back -> data 0..7, rlast only on beat 8.
// - Write 0x11223344 wstrb F, then 0x0000AA00 wstrb 0010 same addr -> readback 0x1122AA44.
// - WRAP read len3 size2 at 0x38 -> beat addresses 0x38,0x3C,0x30,0x34; FIXED len3 -> same word 4 times.
// - rready low 5 cycles mid-burst -> outputs stable, no beat lost.
//   Write len3 with wlast on beat 2 -> bresp 10. AR and AW same cycle -> both accepted.
// - Assert rst mid read burst -> rvalid 0 immediately, arready 1 one cycle after release;
//   with AXI_SLV_DELAY_EN, DELAY=3 -> first rvalid 4 cycles after AR handshake.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 memory-model responder with independent single-burst read and write engines.
// Define AXI_SLV_DELAY_EN to insert DELAY wait cycles before the first read beat and before bvalid.
module axi_sram_slave #(
   parameter int ADDR_W = 16,
   parameter int DELAY  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
`ifdef AXI_SLV_DELAY_EN
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
   logic [3:0] r_dly_q, r_dly_d, w_dly_q, w_dly_d;
`else
   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
`endif
   logic [31:0] mem [2**ADDR_W];
   r_state_t    r_state_q, r_state_d;
   w_state_t    w_state_q, w_state_d;
   logic [3:0]  r_id_q, r_id_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [3:0]  w_id_q, w_id_d, w_len_q, w_len_d;
   logic [4:0]  w_cnt_q, w_cnt_d;
   logic [31:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d, rdata_q, rdata_d;
   logic [2:0]  r_size_q, r_size_d, w_size_q, w_size_d;
   logic [1:0]  r_burst_q, r_burst_d, w_burst_q, w_burst_d, bresp_q, bresp_d;
   logic        arready_q, arready_d, awready_q, awready_d, wr_en, unused_ok;

   // WRAP keeps the low bits inside the aligned (len+1)<<size window
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] inc, mask;
      inc  = a + (32'd1 << size);
      mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
      return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | (inc & mask) : inc;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         {r_id_q, r_len_q, r_cnt_q, r_addr_q, r_size_q, r_burst_q, rdata_q, arready_q} <= '0;
         {w_id_q, w_len_q, w_cnt_q, w_addr_q, w_size_q, w_burst_q, bresp_q, awready_q} <= '0;
`ifdef AXI_SLV_DELAY_EN
         r_dly_q <= '0;
         w_dly_q <= '0;
`endif
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         {r_id_q, r_len_q, r_cnt_q, r_addr_q, r_size_q, r_burst_q, rdata_q, arready_q} <=
            {r_id_d, r_len_d, r_cnt_d, r_addr_d, r_size_d, r_burst_d, rdata_d, arready_d};
         {w_id_q, w_len_q, w_cnt_q, w_addr_q, w_size_q, w_burst_q, bresp_q, awready_q} <=
            {w_id_d, w_len_d, w_cnt_d, w_addr_d, w_size_d, w_burst_d, bresp_d, awready_d};
`ifdef AXI_SLV_DELAY_EN
         r_dly_q <= r_dly_d;
         w_dly_q <= w_dly_d;
`endif
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      {r_id_d, r_len_d, r_cnt_d, r_addr_d, r_size_d, r_burst_d} =
         {r_id_q, r_len_q, r_cnt_q, r_addr_q, r_size_q, r_burst_q};
`ifdef AXI_SLV_DELAY_EN
      r_dly_d = r_dly_q;
`endif
      if (r_state_q == R_IDLE && arready_q && arvalid) begin
         {r_id_d, r_len_d, r_addr_d, r_size_d, r_burst_d} = {arid, arlen, araddr, arsize, arburst};
         r_cnt_d = '0;
`ifdef AXI_SLV_DELAY_EN
         r_dly_d   = 4'(DELAY - 1);
         r_state_d = (DELAY == 0) ? R_BURST : R_WAIT;
`else
         r_state_d = R_BURST;
`endif
      end
`ifdef AXI_SLV_DELAY_EN
      if (r_state_q == R_WAIT) begin
         r_state_d = (r_dly_q == 4'd0) ? R_BURST : R_WAIT;
         r_dly_d   = r_dly_q - 4'd1;
      end
`endif
      if (r_state_q == R_BURST && rready) begin
         r_state_d = rlast ? R_IDLE : R_BURST;
         r_cnt_d   = r_cnt_q + 4'd1;
         r_addr_d  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
      end
      // data is captured when a beat becomes valid, so it holds through rready stalls
      rdata_d   = (r_state_d == R_BURST && (r_state_q != R_BURST || rready)) ?
                  mem[r_addr_d[ADDR_W+1:2]] : rdata_q;
      arready_d = r_state_d == R_IDLE;
   end

   always_comb begin
      w_state_d = w_state_q;
      {w_id_d, w_len_d, w_cnt_d, w_addr_d, w_size_d, w_burst_d, bresp_d} =
         {w_id_q, w_len_q, w_cnt_q, w_addr_q, w_size_q, w_burst_q, bresp_q};
`ifdef AXI_SLV_DELAY_EN
      w_dly_d = w_dly_q;
`endif
      if (w_state_q == W_IDLE && awready_q && awvalid) begin
         {w_id_d, w_len_d, w_addr_d, w_size_d, w_burst_d} = {awid, awlen, awaddr, awsize, awburst};
         w_cnt_d   = '0;
         w_state_d = W_DATA;
      end
      if (w_state_q == W_DATA && wvalid) begin
         w_cnt_d  = w_cnt_q + {4'd0, ~&w_cnt_q};
         w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
         if (wlast) begin
            bresp_d = (w_cnt_q == {1'b0, w_len_q}) ? 2'b00 : 2'b10;
`ifdef AXI_SLV_DELAY_EN
            w_dly_d   = 4'(DELAY - 1);
            w_state_d = (DELAY == 0) ? W_RESP : W_WAIT;
`else
            w_state_d = W_RESP;
`endif
         end
      end
`ifdef AXI_SLV_DELAY_EN
      if (w_state_q == W_WAIT) begin
         w_state_d = (w_dly_q == 4'd0) ? W_RESP : W_WAIT;
         w_dly_d   = w_dly_q - 4'd1;
      end
`endif
      if (w_state_q == W_RESP && bready) w_state_d = W_IDLE;
      awready_d = w_state_d == W_IDLE;
   end

   assign wr_en = w_state_q == W_DATA && wvalid && w_cnt_q <= {1'b0, w_len_q};

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) mem[w_addr_q[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
   end

   assign arready   = arready_q;
   assign awready   = awready_q;
   assign rvalid    = r_state_q == R_BURST;
   assign rlast     = rvalid && r_cnt_q == r_len_q;
   assign rid       = r_id_q;
   assign rdata     = rdata_q;
   assign rresp     = 2'b00;
   assign wready    = w_state_q == W_DATA;
   assign bvalid    = w_state_q == W_RESP;
   assign bid       = w_id_q;
   assign bresp     = bresp_q;
   assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, r_addr_q, w_addr_q, 1'(DELAY)};
endmodule
